mul_bus_master: RTL and testbench
=================================

Name: mul_bus_master

Overview:
- Bus-master sequencer that drives the multiplier slave's register interface on behalf of a simple command/response client.
- Per accepted command it runs the full transaction:
  - writes multiplicand (offset 0x0) and multiplier (0x1);
  - sets interrupt enable (0x3), then start (0x4);
  - waits for m_interrupt;
  - reads NUM_RES_WORDS result words from offset 0x2;
  - writes clear (0x5);
  - returns the product.
- Sits between host-side control logic and the multiplier slave's S_* port.

Parameters:
- BASE_ADDR, 8'h00, slave base address; M_address = BASE_ADDR | offset, with offset in bits [3:0].
- NUM_RES_WORDS, 2, result words read per operation (1..8).
- TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before aborting.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  client command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_cand  in  32  multiplicand.
- cmd_lier  in  32  multiplier.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_result  out  32*NUM_RES_WORDS  product; word i at [32i+31:32i].
- rsp_timeout  out  1  qualifies rsp_valid: operation aborted.
- core_state  in  3  multiplier core state; 3'b000 = core idle.
- M_sel  out  1  slave select.
- M_wr  out  1  1 = write, 0 = read.
- M_address  out  8  slave address.
- M_dout  out  32  write data to the slave (drives S_din).
- M_din  in  32  read data from the slave (S_dout); registered, valid 1 cycle after the read cycle.
- m_interrupt  in  1  slave done interrupt.

Behaviour:
- Reset: single clock; reset is synchronous, active-low on reset_n, sampled at posedge clk.
  - State returns to IDLE.
  - M_sel, M_wr, M_address, M_dout = 0; rsp_valid = 0, rsp_timeout = 0, rsp_result = 0; counters = 0.
  - Reset mid-transaction abandons it; no clear write is issued.
- Bus outputs are decoded from the state register only; there is no combinational path from inputs to M_*.
- Bus outputs when not in a write or read state: M_sel = 0, M_wr = 0, M_address = 0, M_dout = 0.
- States and transitions:
  - IDLE: cmd_ready = 1. When cmd_valid, latch operands, clear rsp_timeout, and go to WR_CAND.
  - WR_CAND: stalls with the bus idle while core_state != 0. When core_state == 0, drive sel=1, wr=1, addr=0x0, data=cand, then go to WR_LIER.
  - WR_LIER: drive sel=1, wr=1, addr=0x1, data=lier. Go to WR_IE.
  - WR_IE: drive a write to 0x3 with data 1. Go to WR_START.
  - WR_START: drive a write to 0x4 with data 1. Clear the timeout counter. Go to WAIT.
  - WAIT: bus idle; the counter increments each cycle.
    - m_interrupt = 1 goes to RD with index 0; interrupt has priority over the timeout in the same cycle.
    - counter == TIMEOUT_CYCLES-1 sets rsp_timeout, zeroes rsp_result, and goes to RESP.
  - RD: drive sel=1, wr=0, addr=0x2. When index > 0, capture M_din into word index-1. Increment index; at index == NUM_RES_WORDS-1, go to CAP.
  - CAP: bus idle; capture M_din into word NUM_RES_WORDS-1. Go to WR_CLR.
  - WR_CLR: drive a write to 0x5 with data 1. Go to RESP.
  - RESP: rsp_valid = 1 for one cycle. Go to IDLE.
- rsp_result and rsp_timeout hold their values until the next command is accepted.
- Latency with core idle:
  - accept at cycle 0; WR_START at cycle 4.
  - interrupt seen in cycle k: rsp_valid at k+NUM_RES_WORDS+3 (k+5 for the default).
- cmd_valid is ignored outside IDLE. There is no queueing.
- Timeout path skips WR_CLR, because the slave rejects clear while opdone = 0. The next command stalls in WR_CAND until the core reports idle.
- The timeout counter is $clog2(TIMEOUT_CYCLES) bits wide and saturates; it cannot wrap.

Decomposition:
- Package mul_bus_pkg:
  - offset constants OFS_CAND=4'h0, OFS_LIER=4'h1, OFS_RESULT=4'h2, OFS_IE=4'h3, OFS_START=4'h4, OFS_CLEAR=4'h5, OFS_DONE=4'h6;
  - CORE_IDLE=3'b000;
  - master state encoding localparams.
- Single module; no sub-module is needed. The timeout counter is inline.

Test Plan:
- Basic: cmd cand=32'h0000_0003, lier=32'h0000_0005 against the slave plus core model.
  - Bus writes appear in order 0x0, 0x1, 0x3, 0x4 in cycles 1-4.
  - Two reads of 0x2 follow, then a write to 0x5.
  - rsp_result=64'h0000_0000_0000_000F, rsp_timeout=0.
- Busy core: hold core_state=3'b010 for 6 cycles after accept. No M_sel during the stall; WR_CAND occurs on the first cycle core_state=0.
- Interrupt latency: bus model asserts m_interrupt 10 cycles after start. Read words returned as 32'hDEAD_BEEF, 32'h1234_5678 give rsp_result=64'h1234_5678_DEAD_BEEF, with rsp_valid exactly 5 cycles after the interrupt.
- Timeout: TIMEOUT_CYCLES=16 and m_interrupt never asserted.
  - rsp_valid with rsp_timeout=1 and rsp_result=0 after 16 WAIT cycles.
  - No write to 0x5 is issued.
- Mid-op reset: drop reset_n for 1 cycle during WAIT. Next cycle all M_* = 0, cmd_ready=1, rsp_result=0, and no rsp_valid.
- Back-to-back: cmd_valid held high with two different commands. The second is accepted only in IDLE, after rsp_valid of the first; both products are correct.

Source files
------------

// File: rtl/mul_bus_pkg.sv
// Shared constants for the multiplier bus master: slave register offsets,
// core idle encoding, master state encoding and an address helper.
package mul_bus_pkg;

    localparam logic [3:0] OFS_CAND   = 4'h0;
    localparam logic [3:0] OFS_LIER   = 4'h1;
    localparam logic [3:0] OFS_RESULT = 4'h2;
    localparam logic [3:0] OFS_IE     = 4'h3;
    localparam logic [3:0] OFS_START  = 4'h4;
    localparam logic [3:0] OFS_CLEAR  = 4'h5;
    localparam logic [3:0] OFS_DONE   = 4'h6;

    localparam logic [2:0] CORE_IDLE  = 3'b000;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_WR_CAND  = 4'd1;
    localparam state_t ST_WR_LIER  = 4'd2;
    localparam state_t ST_WR_IE    = 4'd3;
    localparam state_t ST_WR_START = 4'd4;
    localparam state_t ST_WAIT     = 4'd5;
    localparam state_t ST_RD       = 4'd6;
    localparam state_t ST_CAP      = 4'd7;
    localparam state_t ST_WR_CLR   = 4'd8;
    localparam state_t ST_RESP     = 4'd9;

    // Slave register address: base with the offset in the low nibble.
    function automatic logic [7:0] bus_addr(input logic [7:0] base, input logic [3:0] ofs);
        return base | {4'h0, ofs};
    endfunction

endpackage

// File: rtl/mul_bus_master.sv
// Bus-master sequencer driving the multiplier slave for one command at a time.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | cmd_ready high, waiting for a command
// WR_CAND  | write multiplicand once the core reports idle (bus idle until then)
// WR_LIER  | write multiplier
// WR_IE    | write interrupt enable
// WR_START | write start, clear timeout counter
// WAIT     | bus idle, wait for m_interrupt or timeout
// RD       | read result words from the result register
// CAP      | capture the last read word
// WR_CLR   | write clear
// RESP     | one-cycle response pulse
//
// The M_* outputs are registers loaded with the decode of the state being
// entered, so they depend only on flops. The core-idle test for WR_CAND is
// therefore made one cycle ahead: the multiplicand write appears in the cycle
// after core_state is seen idle.
module mul_bus_master
    import mul_bus_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR      = 8'h00,
    parameter int         NUM_RES_WORDS  = 2,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [31:0]                   cmd_cand,
    input  logic [31:0]                   cmd_lier,
    output logic                          rsp_valid,
    output logic [32*NUM_RES_WORDS-1:0]   rsp_result,
    output logic                          rsp_timeout,
    input  logic [2:0]                    core_state,
    output logic                          M_sel,
    output logic                          M_wr,
    output logic [7:0]                    M_address,
    output logic [31:0]                   M_dout,
    input  logic [31:0]                   M_din,
    input  logic                          m_interrupt
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int               RES_W    = 32 * NUM_RES_WORDS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       IDX_LAST = 4'(NUM_RES_WORDS - 1);

    state_t           state_q;
    state_t           state_nxt;
    logic [31:0]      cand_q;
    logic [31:0]      lier_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       idx_q;
    logic [RES_W-1:0] res_q;
    logic             tmo_q;
    logic             tmo_hit;

    logic             sel_q;
    logic             wr_q;
    logic [7:0]       addr_q;
    logic [31:0]      dout_q;
    logic             sel_nxt;
    logic             wr_nxt;
    logic [7:0]       addr_nxt;
    logic [31:0]      dout_nxt;

    assign tmo_hit = (cnt_q == CNT_LAST);

    // State register together with the registered bus outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 8'h00;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_nxt;
            sel_q   <= sel_nxt;
            wr_q    <= wr_nxt;
            addr_q  <= addr_nxt;
            dout_q  <= dout_nxt;
        end
    end

    // Next-state selection
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:     if (cmd_valid) state_nxt = ST_WR_CAND;
            // sel_q high here means the multiplicand write is on the bus now
            ST_WR_CAND:  if (sel_q) state_nxt = ST_WR_LIER;
            ST_WR_LIER:  state_nxt = ST_WR_IE;
            ST_WR_IE:    state_nxt = ST_WR_START;
            ST_WR_START: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (m_interrupt)  state_nxt = ST_RD;
                else if (tmo_hit) state_nxt = ST_RESP;
            end
            ST_RD:       if (idx_q == IDX_LAST) state_nxt = ST_CAP;
            ST_CAP:      state_nxt = ST_WR_CLR;
            ST_WR_CLR:   state_nxt = ST_RESP;
            ST_RESP:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Bus decode for the state being entered; registered above
    always_comb begin
        sel_nxt  = 1'b0;
        wr_nxt   = 1'b0;
        addr_nxt = 8'h00;
        dout_nxt = 32'h0;
        case (state_nxt)
            ST_WR_CAND: begin
                if (core_state == CORE_IDLE) begin
                    sel_nxt  = 1'b1;
                    wr_nxt   = 1'b1;
                    addr_nxt = bus_addr(BASE_ADDR, OFS_CAND);
                    dout_nxt = (state_q == ST_IDLE) ? cmd_cand : cand_q;
                end
            end
            ST_WR_LIER: begin
                sel_nxt  = 1'b1;
                wr_nxt   = 1'b1;
                addr_nxt = bus_addr(BASE_ADDR, OFS_LIER);
                dout_nxt = lier_q;
            end
            ST_WR_IE: begin
                sel_nxt  = 1'b1;
                wr_nxt   = 1'b1;
                addr_nxt = bus_addr(BASE_ADDR, OFS_IE);
                dout_nxt = 32'h1;
            end
            ST_WR_START: begin
                sel_nxt  = 1'b1;
                wr_nxt   = 1'b1;
                addr_nxt = bus_addr(BASE_ADDR, OFS_START);
                dout_nxt = 32'h1;
            end
            ST_RD: begin
                sel_nxt  = 1'b1;
                addr_nxt = bus_addr(BASE_ADDR, OFS_RESULT);
            end
            ST_WR_CLR: begin
                sel_nxt  = 1'b1;
                wr_nxt   = 1'b1;
                addr_nxt = bus_addr(BASE_ADDR, OFS_CLEAR);
                dout_nxt = 32'h1;
            end
            default: ;
        endcase
    end

    // Operand latch, saturating timeout counter, read index and result capture
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cand_q <= 32'h0;
            lier_q <= 32'h0;
            cnt_q  <= '0;
            idx_q  <= 4'd0;
            res_q  <= '0;
            tmo_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cand_q <= cmd_cand;
                        lier_q <= cmd_lier;
                        tmo_q  <= 1'b0;
                    end
                end
                ST_WR_START: cnt_q <= '0;
                ST_WAIT: begin
                    if (cnt_q != CNT_SAT) cnt_q <= cnt_q + CNT_ONE;
                    if (m_interrupt) begin
                        idx_q <= 4'd0;
                    end else if (tmo_hit) begin
                        tmo_q <= 1'b1;
                        res_q <= '0;
                    end
                end
                ST_RD: begin
                    // M_din lags the read by one cycle, so it holds word idx-1
                    if (idx_q != 4'd0) res_q[32*(int'(idx_q)-1) +: 32] <= M_din;
                    idx_q <= idx_q + 4'd1;
                end
                ST_CAP: res_q[RES_W-32 +: 32] <= M_din;
                default: ;
            endcase
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_result  = res_q;
    assign rsp_timeout = tmo_q;
    assign M_sel       = sel_q;
    assign M_wr        = wr_q;
    assign M_address   = addr_q;
    assign M_dout      = dout_q;

endmodule

// File: tb/tb_mul_bus_master.sv
// Self-checking bench for mul_bus_master with a behavioural slave/core model.
module tb_mul_bus_master;

    localparam int         NW   = 2;
    localparam int         TMO  = 16;
    localparam logic [7:0] BASE = 8'h00;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [31:0]      cmd_cand = 32'h0;
    logic [31:0]      cmd_lier = 32'h0;
    logic             rsp_valid;
    logic [32*NW-1:0] rsp_result;
    logic             rsp_timeout;
    logic [2:0]       core_state = 3'b000;
    logic             M_sel;
    logic             M_wr;
    logic [7:0]       M_address;
    logic [31:0]      M_dout;
    logic [31:0]      M_din = 32'h0;
    logic             m_interrupt = 1'b0;

    mul_bus_master #(
        .BASE_ADDR(BASE),
        .NUM_RES_WORDS(NW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_cand(cmd_cand), .cmd_lier(cmd_lier),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
        .core_state(core_state),
        .M_sel(M_sel), .M_wr(M_wr), .M_address(M_address), .M_dout(M_dout),
        .M_din(M_din), .m_interrupt(m_interrupt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
    } bus_t;

    typedef struct {
        string       name;
        logic [31:0] cand;
        logic [31:0] lier;
        int          busy;
        int          d;
        logic        ovr;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [63:0] exp_res;
        logic        exp_to;
    } vec_t;

    bus_t        bus_q[$];
    int          acc_q[$];
    int          rsp_cyc_q[$];
    logic [63:0] rsp_res_q[$];
    logic        rsp_to_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] s_cand = 32'h0;
    logic [31:0] s_lier = 32'h0;
    int          irq_delay = -1;
    int          irq_cnt = 0;
    int          busy_cnt = 0;
    int          rd_ptr = 0;
    logic        pend_rd = 1'b0;
    logic        ovr = 1'b0;
    logic [31:0] ovr_w0 = 32'h0;
    logic [31:0] ovr_w1 = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] slave_word(input int i);
        logic [63:0] prod;
        prod = {32'h0, s_cand} * {32'h0, s_lier};
        if (i >= NW) return 32'hBAD0_0000;
        if (ovr) return (i == 0) ? ovr_w0 : ovr_w1;
        return prod[32*i +: 32];
    endfunction

    // One clock: record acceptance, advance the slave/core model, log bus and responses.
    task automatic step();
        bus_t e;
        if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
        @(posedge clk);
        #1;
        cyc++;
        if (pend_rd) begin
            M_din = slave_word(rd_ptr);
            rd_ptr++;
            pend_rd = 1'b0;
        end
        if (irq_cnt > 0) begin
            irq_cnt--;
            if (irq_cnt == 0) m_interrupt = 1'b1;
        end
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) core_state = 3'b000;
        end
        if (M_sel) begin
            e.cyc = cyc; e.wr = M_wr; e.addr = M_address; e.data = M_dout;
            bus_q.push_back(e);
            if (!M_wr) pend_rd = 1'b1;
            else begin
                case (M_address[3:0])
                    4'h0: s_cand = M_dout;
                    4'h1: s_lier = M_dout;
                    4'h4: begin rd_ptr = 0; if (irq_delay > 0) irq_cnt = irq_delay; end
                    4'h5: m_interrupt = 1'b0;
                    default: ;
                endcase
            end
        end else begin
            chk($sformatf("bus_idle@%0d", cyc), {23'h0, M_wr, M_address, M_dout}, 64'h0);
        end
        if (rsp_valid) begin
            rsp_cyc_q.push_back(cyc);
            rsp_res_q.push_back(rsp_result);
            rsp_to_q.push_back(rsp_timeout);
        end
    endtask

    task automatic clear_logs();
        bus_q.delete(); acc_q.delete();
        rsp_cyc_q.delete(); rsp_res_q.delete(); rsp_to_q.delete();
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!cmd_ready && n < 60) begin step(); n++; end
        chk({name, ".ready"}, {63'h0, cmd_ready}, 64'h1);
    endtask

    function automatic bus_t mk(input int c, input logic wr, input logic [3:0] ofs, input logic [31:0] d);
        bus_t e;
        e.cyc = c; e.wr = wr; e.addr = BASE | {4'h0, ofs}; e.data = d;
        return e;
    endfunction

    // Reference timeline: writes start the cycle after the core is seen idle;
    // interrupt d cycles after start (valid while 1..TMO), reads follow it,
    // then capture, clear and response; otherwise response after TMO wait cycles.
    task automatic check_txn(input string name, input int a, input logic [31:0] cand,
                             input logic [31:0] lier, input int busy, input int d,
                             input logic [63:0] exp_res, input logic exp_to,
                             inout int bi, inout int ri);
        bus_t exp_q[$];
        int w, s, k, rsp;
        w = a + busy + 1;
        s = w + 3;
        exp_q.push_back(mk(w, 1'b1, 4'h0, cand));
        exp_q.push_back(mk(w + 1, 1'b1, 4'h1, lier));
        exp_q.push_back(mk(w + 2, 1'b1, 4'h3, 32'h1));
        exp_q.push_back(mk(s, 1'b1, 4'h4, 32'h1));
        if (d >= 1 && d <= TMO) begin
            k = s + d;
            for (int i = 0; i < NW; i++) exp_q.push_back(mk(k + 1 + i, 1'b0, 4'h2, 32'h0));
            exp_q.push_back(mk(k + NW + 2, 1'b1, 4'h5, 32'h1));
            rsp = k + NW + 3;
        end else begin
            rsp = s + TMO + 1;
        end
        foreach (exp_q[i]) begin
            if (bi >= bus_q.size()) begin
                chk($sformatf("%s.bus%0d.present", name, i), 64'h0, 64'h1);
            end else begin
                chk($sformatf("%s.bus%0d.cyc", name, i), 64'(bus_q[bi].cyc), 64'(exp_q[i].cyc));
                chk($sformatf("%s.bus%0d.wr", name, i), {63'h0, bus_q[bi].wr}, {63'h0, exp_q[i].wr});
                chk($sformatf("%s.bus%0d.addr", name, i), {56'h0, bus_q[bi].addr}, {56'h0, exp_q[i].addr});
                if (exp_q[i].wr)
                    chk($sformatf("%s.bus%0d.data", name, i), {32'h0, bus_q[bi].data}, {32'h0, exp_q[i].data});
            end
            bi++;
        end
        if (ri >= rsp_cyc_q.size()) begin
            chk({name, ".rsp_present"}, 64'h0, 64'h1);
        end else begin
            chk({name, ".rsp_cyc"}, 64'(rsp_cyc_q[ri]), 64'(rsp));
            chk({name, ".rsp_result"}, rsp_res_q[ri], exp_res);
            chk({name, ".rsp_timeout"}, {63'h0, rsp_to_q[ri]}, {63'h0, exp_to});
        end
        ri++;
    endtask

    task automatic run_txn(input vec_t v);
        int n, a, bi, ri;
        clear_logs();
        wait_ready(v.name);
        ovr = v.ovr; ovr_w0 = v.w0; ovr_w1 = v.w1;
        irq_delay = v.d;
        cmd_cand = v.cand; cmd_lier = v.lier;
        core_state = (v.busy > 0) ? 3'b010 : 3'b000;
        busy_cnt = v.busy;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (rsp_cyc_q.size() == 0 && n < 200) begin step(); n++; end
        step(); step();
        chk({v.name, ".accepts"}, 64'(acc_q.size()), 64'd1);
        a = (acc_q.size() > 0) ? acc_q[0] : cyc;
        bi = 0; ri = 0;
        check_txn(v.name, a, v.cand, v.lier, v.busy, v.d, v.exp_res, v.exp_to, bi, ri);
        chk({v.name, ".bus_count"}, 64'(bus_q.size()), 64'(bi));
        chk({v.name, ".rsp_count"}, 64'(rsp_cyc_q.size()), 64'(ri));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vec_t v;
        int   n, bi, ri, rst_cyc, post;
        logic [31:0] c1, l1, c2, l2;

        vecs[0] = '{"basic",        32'h3,         32'h5,         0, 4,  1'b0, 32'h0, 32'h0, 64'h0000_0000_0000_000F, 1'b0};
        vecs[1] = '{"busy_core",    32'h7,         32'h9,         7, 2,  1'b0, 32'h0, 32'h0, 64'd63,                  1'b0};
        vecs[2] = '{"irq_latency",  32'h2,         32'h3,         0, 10, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 64'h1234_5678_DEAD_BEEF, 1'b0};
        vecs[3] = '{"timeout",      32'h3,         32'h5,         0, -1, 1'b0, 32'h0, 32'h0, 64'h0,                   1'b1};
        vecs[4] = '{"irq_at_limit", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 16, 1'b0, 32'h0, 32'h0, 64'hFFFF_FFFE_0000_0001, 1'b0};
        vecs[5] = '{"irq_first",    32'h0001_0000, 32'h0001_0000, 1, 1,  1'b0, 32'h0, 32'h0, 64'h0000_0001_0000_0000, 1'b0};

        // Reset state
        reset_n = 1'b0;
        repeat (3) step();
        chk("reset.cmd_ready", {63'h0, cmd_ready}, 64'h1);
        chk("reset.rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("reset.rsp_result", rsp_result, 64'h0);
        chk("reset.rsp_timeout", {63'h0, rsp_timeout}, 64'h0);
        chk("reset.bus", {22'h0, M_sel, M_wr, M_address, M_dout}, 64'h0);
        reset_n = 1'b1;
        step();

        foreach (vecs[i]) run_txn(vecs[i]);

        // Reset during WAIT abandons the transaction without a clear write
        clear_logs();
        wait_ready("mid_reset");
        irq_delay = -1; ovr = 1'b0;
        cmd_cand = 32'h11; cmd_lier = 32'h22; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (6) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        rst_cyc = cyc;
        chk("mid_reset.bus", {22'h0, M_sel, M_wr, M_address, M_dout}, 64'h0);
        chk("mid_reset.cmd_ready", {63'h0, cmd_ready}, 64'h1);
        chk("mid_reset.rsp_result", rsp_result, 64'h0);
        chk("mid_reset.rsp_valid", {63'h0, rsp_valid}, 64'h0);
        repeat (20) step();
        chk("mid_reset.no_rsp", 64'(rsp_cyc_q.size()), 64'd0);
        post = 0;
        foreach (bus_q[i]) if (bus_q[i].cyc >= rst_cyc) post++;
        chk("mid_reset.no_bus_after", 64'(post), 64'd0);

        // Back-to-back with cmd_valid held high
        clear_logs();
        wait_ready("b2b");
        c1 = 32'h0000_1234; l1 = 32'h0000_0100; c2 = 32'h8000_0001; l2 = 32'h0000_0003;
        irq_delay = 3; ovr = 1'b0;
        cmd_cand = c1; cmd_lier = l1; cmd_valid = 1'b1;
        step();
        cmd_cand = c2; cmd_lier = l2;
        n = 0;
        while (acc_q.size() < 2 && n < 100) begin step(); n++; end
        cmd_valid = 1'b0;
        n = 0;
        while (rsp_cyc_q.size() < 2 && n < 100) begin step(); n++; end
        step();
        chk("b2b.accepts", 64'(acc_q.size()), 64'd2);
        if (acc_q.size() == 2 && rsp_cyc_q.size() >= 1)
            chk("b2b.second_accept_cyc", 64'(acc_q[1]), 64'(rsp_cyc_q[0] + 1));
        bi = 0; ri = 0;
        check_txn("b2b_first", (acc_q.size() > 0) ? acc_q[0] : cyc, c1, l1, 0, 3,
                  {32'h0, c1} * {32'h0, l1}, 1'b0, bi, ri);
        check_txn("b2b_second", (acc_q.size() > 1) ? acc_q[1] : cyc, c2, l2, 0, 3,
                  {32'h0, c2} * {32'h0, l2}, 1'b0, bi, ri);
        chk("b2b.bus_count", 64'(bus_q.size()), 64'(bi));

        // Randomized transactions against the reference timeline
        for (int t = 0; t < 12; t++) begin
            v.name = $sformatf("rand%0d", t);
            v.cand = $urandom;
            v.lier = $urandom;
            v.busy = $urandom_range(0, 4);
            v.d    = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, TMO));
            v.ovr  = 1'b0; v.w0 = 32'h0; v.w1 = 32'h0;
            v.exp_to  = (v.d < 1);
            v.exp_res = v.exp_to ? 64'h0 : ({32'h0, v.cand} * {32'h0, v.lier});
            run_txn(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
